dcache_fill_fsm: RTL and testbench
==================================

# dcache_fill_fsm

Miss-handling controller for the data cache. When the cache reports a miss, it fetches the 16-byte (8-word) block containing the miss address from main memory, one word per cycle. It steers each returned word into the data array, then commits the new tag to the metadata array with the last word. It sits between the data cache (consumes `miss_data_cache`, drives `write_data_array` / `write_tag_array`) and the multi-cycle, pipelined main memory.

## Interface
Parameters:
- `WORDS`, 8: words per block. Fixed at 8; the address math assumes it.
- `CNT_W`, 4: counter width. Must hold the value `WORDS`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `miss_detected`, in, 1: cache miss. Sampled only in IDLE.
- `miss_address`, in, 16: byte address of the missing access. Sampled with `miss_detected`.
- `memory_data_valid`, in, 1: main memory returns one word this cycle.
- `fsm_busy`, out, 1: a fill is in progress. The pipeline stalls on it.
- `mem_read_en`, out, 1: issue a read of `memory_address` this cycle.
- `memory_address`, out, 16: word request address to main memory.
- `fill_address`, out, 16: cache address of the word returned this cycle. Drives the word decoder (bits [3:1]).
- `write_data_array`, out, 1: write the returned word into the data array.
- `write_tag_array`, out, 1: write the new tag, valid and LRU state into the metadata array.

## Operation
- States: IDLE, FILL.
- Registers:
  - `base`: 16 bits, low 4 bits always 0.
  - `req_cnt`: `CNT_W` bits.
  - `rsp_cnt`: `CNT_W` bits.
- IDLE -> FILL on a clock edge with `miss_detected`=1. On that edge:
  - `base` <= {miss_address[15:4], 4'b0}
  - `req_cnt` <= 0
  - `rsp_cnt` <= 0
- In FILL, request side:
  - `mem_read_en` = (req_cnt < 8)
  - `memory_address` = base + {req_cnt[2:0], 1'b0}
  - `req_cnt` increments on each cycle with `mem_read_en`=1 and saturates at 8.
  - Requests go out back-to-back with no stall. Memory accepts one per cycle.
- In FILL, response side: when `memory_data_valid`=1:
  - `write_data_array` = 1
  - `fill_address` = base + {rsp_cnt[2:0], 1'b0}
  - `rsp_cnt` increments.
- Completion: when `memory_data_valid`=1 and `rsp_cnt`==7:
  - `write_tag_array` = 1 in the same cycle as the last data write.
  - FSM returns to IDLE on the next edge.
- Responses are counted, never timed, so any memory latency of 1 or more cycles works.
- `fsm_busy` = (state==FILL).
- All request/response outputs are combinational from state, counters and `memory_data_valid`.
- Inactive outputs:
  - `memory_address` and `fill_address` are 0 when their enable is low.
  - In IDLE all outputs are 0.
- Address arithmetic is 16-bit. A block never crosses a 16-byte boundary, so no carry out of bit 3 occurs.

## Timing
- Reset: state=IDLE, `base`=0, both counters 0. Every output is 0 immediately (asynchronous), and stays 0 until a miss is taken.
- Cycle 0: `miss_detected`=1 in IDLE. Outputs are still 0 in this cycle.
- Cycles 1..8: `fsm_busy`=1, with requests for words 0..7 one per cycle.
- With memory latency L, data for word k arrives in cycle 1+k+L. `write_tag_array` pulses in cycle 8+L, and `fsm_busy` drops in cycle 9+L.
- Minimum fill time is 9+L cycles from miss to IDLE.
- Boundary and abnormal cases:
  - `miss_detected` during FILL: ignored, no restart and no re-latch. The cache re-asserts the miss after the fill.
  - `memory_data_valid` in IDLE, or after the 8th response: ignored, no writes.
  - `miss_detected` held high in the cycle the FSM returns to IDLE: a new fill starts on the following edge. There is no dead cycle beyond the single IDLE cycle.
  - `rst` mid-fill: immediate return to IDLE with all outputs 0. Late memory responses are then ignored.
  - `miss_address` changing during FILL has no effect.

## Test plan
- Reset, then idle: hold `rst`=1 for 2 cycles, release, and wait 5 cycles with no miss -> all outputs 0 throughout and `fsm_busy`=0.
- Basic fill, L=4: miss at 0x1236 -> `memory_address` 0x1230, 0x1232, …, 0x123E on cycles 1..8, with `mem_read_en`=1 only on those cycles. Then:
  - `write_data_array` on cycles 5..12 with `fill_address` 0x1230..0x123E
  - `write_tag_array` only on cycle 12
  - `fsm_busy` high on cycles 1..12
- Back-to-back misses: hold `miss_detected`=1 continuously with address 0xFFF2 then 0x0004 -> two complete fills, bases 0xFFF0 and 0x0000, separated by exactly one IDLE cycle.
- Spurious inputs:
  - `memory_data_valid` pulsed in IDLE -> no writes.
  - `miss_detected` toggled mid-fill with address 0x4000 -> the fill completes for the original base.
  - A 9th valid after completion -> ignored.
- Reset mid-fill: assert `rst` in cycle 6 of a fill (3 responses received) -> outputs 0 in the same cycle. Remaining valids are ignored, and the next miss at 0x0A00 performs a full 8-word fill from 0x0A00.
- Variable latency: memory returns words with gaps (valid on cycles 4, 5, 9, 10, 11, 15, 16, 20) -> 8 data writes in order, `write_tag_array` on cycle 20, and IDLE at cycle 21.

Source files
------------

// File: rtl/dcache_fill_fsm.sv
// Data-cache miss handler: fetches the 8-word block holding the miss address,
// streams each returned word into the data array and commits the tag with the last word.
module dcache_fill_fsm #(
  parameter int WORDS = 8,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        mem_read_en,
  output logic [15:0] memory_address,
  output logic [15:0] fill_address,
  output logic        write_data_array,
  output logic        write_tag_array
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

  state_t           state, state_next;
  logic [15:0]      base, base_next;
  logic [CNT_W-1:0] req_cnt, req_cnt_next;
  logic [CNT_W-1:0] rsp_cnt, rsp_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      req_cnt <= '0;
      rsp_cnt <= '0;
    end else begin
      state   <= state_next;
      base    <= base_next;
      req_cnt <= req_cnt_next;
      rsp_cnt <= rsp_cnt_next;
    end
  end

  always_comb begin
    state_next       = state;
    base_next        = base;
    req_cnt_next     = req_cnt;
    rsp_cnt_next     = rsp_cnt;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    fill_address     = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        if (miss_detected) begin
          state_next   = FILL;
          base_next    = {miss_address[15:4], 4'b0};
          req_cnt_next = '0;
          rsp_cnt_next = '0;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        // Requests issue back-to-back; the counter parks at WORDS once all are out.
        if (req_cnt < CNT_FULL) begin
          mem_read_en    = 1'b1;
          memory_address = base + {12'b0, req_cnt[2:0], 1'b0};
          req_cnt_next   = req_cnt + 1'b1;
        end
        // Responses are counted rather than timed, so any memory latency works.
        if (memory_data_valid && (rsp_cnt < CNT_FULL)) begin
          write_data_array = 1'b1;
          fill_address     = base + {12'b0, rsp_cnt[2:0], 1'b0};
          rsp_cnt_next     = rsp_cnt + 1'b1;
          if (rsp_cnt == CNT_LAST) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_fill_fsm.sv
// Directed bench for dcache_fill_fsm: each cycle's expected outputs are queued
// with the stimulus and compared at the following falling edge.
module tb_dcache_fill_fsm;

  typedef struct packed {
    logic        busy;
    logic        rd;
    logic        wd;
    logic        wt;
    logic [15:0] maddr;
    logic [15:0] faddr;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, mem_read_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_address;

  out_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_id = 0;

  dcache_fill_fsm #(.WORDS(8), .CNT_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .fill_address      (fill_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int id, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, id, obs, expv);
    end
  endtask

  // Monitor: pops one expected record per cycle and compares all outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e;
      e = exp_q.pop_front();
      chk("fsm_busy",         cyc_id, {15'b0, fsm_busy},         {15'b0, e.busy});
      chk("mem_read_en",      cyc_id, {15'b0, mem_read_en},      {15'b0, e.rd});
      chk("memory_address",   cyc_id, memory_address,            e.maddr);
      chk("write_data_array", cyc_id, {15'b0, write_data_array}, {15'b0, e.wd});
      chk("fill_address",     cyc_id, fill_address,              e.faddr);
      chk("write_tag_array",  cyc_id, {15'b0, write_tag_array},  {15'b0, e.wt});
      $display("step=%0d busy=%b rd=%b maddr=%h wd=%b faddr=%h wt=%b",
               cyc_id, fsm_busy, mem_read_en, memory_address,
               write_data_array, fill_address, write_tag_array);
      cyc_id++;
    end
  end

  // Drive one cycle's inputs (just after a rising edge) and queue its expected outputs.
  task automatic step(input logic r, input logic md, input logic [15:0] ma,
                      input logic mv, input out_t e);
    rst = r;
    miss_detected = md;
    miss_address = ma;
    memory_data_valid = mv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_valid(input int c, input int vc[8]);
    for (int k = 0; k < 8; k++) if (vc[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Expected outputs for cycle c of a fill (c=0 is the miss cycle), from the timing description.
  function automatic out_t fill_exp(input logic [15:0] b, input int c, input int vc[8]);
    out_t e;
    e = '0;
    if (c >= 1 && c <= vc[7]) e.busy = 1'b1;
    if (c >= 1 && c <= 8) begin
      e.rd = 1'b1;
      e.maddr = b + 16'((c - 1) * 2);
    end
    for (int k = 0; k < 8; k++) begin
      if (vc[k] == c) begin
        e.wd = 1'b1;
        e.faddr = b + 16'(k * 2);
        if (k == 7) e.wt = 1'b1;
      end
    end
    return e;
  endfunction

  initial begin
    int vc[8];
    out_t z;
    z = '0;
    @(posedge clk);
    #1;

    // Reset held two cycles, then idle with a stray memory valid.
    step(1'b1, 1'b0, 16'h0000, 1'b0, z);
    step(1'b1, 1'b0, 16'h0000, 1'b0, z);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 16'h0000, (c == 2), z);

    // Basic fill, latency 4, then a 9th valid once back in IDLE.
    vc = '{5, 6, 7, 8, 9, 10, 11, 12};
    for (int c = 0; c <= 12; c++)
      step(1'b0, (c == 0), 16'h1236, is_valid(c, vc), fill_exp(16'h1230, c, vc));
    step(1'b0, 1'b0, 16'h0000, 1'b1, z);
    step(1'b0, 1'b0, 16'h0000, 1'b0, z);

    // Back-to-back misses with miss held high; the second starts in the single IDLE cycle.
    vc = '{2, 3, 4, 5, 6, 7, 8, 9};
    for (int c = 0; c <= 9; c++)
      step(1'b0, 1'b1, 16'hFFF2, is_valid(c, vc), fill_exp(16'hFFF0, c, vc));
    for (int c = 0; c <= 9; c++)
      step(1'b0, 1'b1, 16'h0004, is_valid(c, vc), fill_exp(16'h0000, c, vc));
    step(1'b0, 1'b0, 16'h0000, 1'b0, z);

    // Miss toggled mid-fill with another address: ignored.
    vc = '{3, 4, 5, 6, 7, 8, 9, 10};
    for (int c = 0; c <= 11; c++)
      step(1'b0, (c == 0) || (c == 3) || (c == 4) || (c == 6),
           (c == 0) ? 16'h2468 : 16'h4000, is_valid(c, vc), fill_exp(16'h2460, c, vc));

    // Reset in cycle 6 after three responses; later valids ignored.
    vc = '{3, 4, 5, 6, 7, 8, 9, 10};
    for (int c = 0; c <= 5; c++)
      step(1'b0, (c == 0), 16'h3338, is_valid(c, vc), fill_exp(16'h3330, c, vc));
    step(1'b1, 1'b0, 16'h0000, 1'b1, z);
    for (int c = 7; c <= 10; c++) step(1'b0, 1'b0, 16'h0000, 1'b1, z);
    vc = '{2, 3, 4, 5, 6, 7, 8, 9};
    for (int c = 0; c <= 10; c++)
      step(1'b0, (c == 0), 16'h0A00, is_valid(c, vc), fill_exp(16'h0A00, c, vc));

    // Variable latency with gaps in the response stream.
    vc = '{4, 5, 9, 10, 11, 15, 16, 20};
    for (int c = 0; c <= 22; c++)
      step(1'b0, (c == 0), 16'h7A3C, is_valid(c, vc), fill_exp(16'h7A30, c, vc));

    step(1'b0, 1'b0, 16'h0000, 1'b0, z);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain remaining=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
